subtractor_32: RTL and testbench
================================

# subtractor_32

32-bit two's-complement subtractor computing out = A − B with a registered result and optional status flags. It serves as the subtract datapath primitive for the ALU and branch-compare logic. Internally it uses a structural carry-lookahead adder fed with A, ~B and carry-in 1. The behavioural `-` operator is not used.

## Interface
- Parameters: none. Width is fixed at 32 and is taken from the shared package.
- clock  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high; clears all outputs.
- A  in  32  minuend, sampled every rising edge.
- B  in  32  subtrahend, sampled every rising edge.
- out  out  32  registered A − B, modulo 2^32.
- overflow  out  1  signed overflow of the registered result. Present only with SUBTRACT_32_FLAGS_EN.
- borrow  out  1  unsigned borrow (A < B unsigned). Present only with SUBTRACT_32_FLAGS_EN.
- zero  out  1  registered result equals 0. Present only with SUBTRACT_32_FLAGS_EN.

## Operation
- Combinational core computes sum = A + ~B + 1 through four 8-bit CLA blocks.
- A second-level lookahead uses the block generate/propagate signals to produce the block carries c8, c16, c24 and c32.
- Result is truncated to 32 bits. Wrap-around is silent: 0 − 1 = 0xFFFFFFFF.
- overflow = (A[31] ≠ B[31]) & (sum[31] ≠ A[31]).
- borrow = ~c32.
- zero = (sum == 0).
- All outputs are registered together, so flags always correspond to the same operand pair as out.
- There is no handshake and no enable. A new operation is accepted every cycle.
- Operands are treated as two's-complement for overflow and as unsigned for borrow. The bit pattern of out is identical in both interpretations.

## Timing
- Latency is exactly 1 cycle: out at edge n+1 reflects A/B sampled at edge n.
- Throughput is 1 result per cycle.
- Reset has priority over new operands. While reset is high at an edge, out = 0, overflow = 0, borrow = 0 and zero = 0.
- zero reads 0 during reset. It is a status flag, not a comparison of the reset value.
- Reset asserted mid-stream discards the in-flight result. The first valid result appears 1 cycle after the first edge with reset low.
- Before the first reset, output values are undefined.
- The critical path is through the CLA and must close at the processor clock within one cycle.

## Configuration
- SUBTRACT_32_FLAGS_EN defined:
  - the overflow, borrow and zero ports and their flag registers exist;
  - the c32 carry-out is routed to the borrow logic.
- SUBTRACT_32_FLAGS_EN undefined:
  - the ports are absent, and only clock, reset, A, B and out exist;
  - the flag logic and registers are not compiled;
  - out behaviour is identical in both builds.

## Structure
- Shared package sub32_pkg holds:
  - DATA_W = 32;
  - CLA_BLOCK_W = 8;
  - NUM_BLOCKS = 4;
  - RESET_VALUE = 32'h0.
- Sub-module cla_8:
  - inputs: 8-bit a, 8-bit b, cin;
  - outputs: 8-bit sum, block generate G, block propagate P.
- Top level contains the B inversion, carry-in 1, four cla_8 instances, the second-level lookahead carry unit, flag logic and output registers.

## Test plan
- Reset, then B = 0 and A = 0..9 one per cycle -> out = 0..9, each one cycle after its operand; overflow = 0 and borrow = 0 throughout. zero = 1 only for A = 0.
- A = 5, B = 7 -> out = 0xFFFFFFFE, borrow = 1, overflow = 0, zero = 0.
- A = 0x80000000, B = 1 -> out = 0x7FFFFFFF, overflow = 1, borrow = 0.
- A = 0x7FFFFFFF, B = 0xFFFFFFFF -> out = 0x80000000, overflow = 1, borrow = 1.
- A = B = 0xDEADBEEF -> out = 0, zero = 1, borrow = 0, overflow = 0.
- Stream of nonzero results with reset asserted for one edge mid-stream -> out = 0 and flags = 0 on that edge; the correct result resumes on the next edge after reset deasserts.

Source files
------------

// File: rtl/sub32_pkg.sv
// Shared widths, reset value and the carry-lookahead helper for the 32-bit subtractor.
package sub32_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned CLA_BLOCK_W = 8;
  localparam int unsigned NUM_BLOCKS  = 4;

  localparam logic [DATA_W-1:0] RESET_VALUE = 32'h0;

  // Flattened lookahead carry into position n: OR over j<n of (g[j] & p[n-1:j+1]), plus (p[n-1:0] & cin).
  function automatic logic lookahead_carry(input logic [CLA_BLOCK_W-1:0] g,
                                           input logic [CLA_BLOCK_W-1:0] p,
                                           input logic                   cin,
                                           input int unsigned            n);
    logic c;
    logic prod;
    c    = 1'b0;
    prod = 1'b1;
    for (int j = int'(CLA_BLOCK_W) - 1; j >= 0; j--) begin
      if (j < int'(n)) begin
        c    = c | (prod & g[j]);
        prod = prod & p[j];
      end
    end
    return c | (prod & cin);
  endfunction

endpackage

// File: rtl/cla_8.sv
// 8-bit carry-lookahead adder block exporting block generate/propagate for a second-level unit.
module cla_8
  import sub32_pkg::*;
(
  input  logic [CLA_BLOCK_W-1:0] a,
  input  logic [CLA_BLOCK_W-1:0] b,
  input  logic                   cin,
  output logic [CLA_BLOCK_W-1:0] sum,
  output logic                   G,
  output logic                   P
);

  logic [CLA_BLOCK_W-1:0] g;
  logic [CLA_BLOCK_W-1:0] p;
  logic [CLA_BLOCK_W-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every internal carry is computed directly from g/p/cin, not rippled.
  always_comb begin
    c = '0;
    for (int unsigned i = 0; i < CLA_BLOCK_W; i++) begin
      c[i] = lookahead_carry(g, p, cin, i);
    end
  end

  assign sum = p ^ c;
  assign G   = lookahead_carry(g, p, 1'b0, CLA_BLOCK_W);
  assign P   = &p;

endmodule

// File: rtl/subtractor_32.sv
// Registered 32-bit subtractor out = A - B built as A + ~B + 1 on a two-level CLA.
// Define SUBTRACT_32_FLAGS_EN to add the overflow, borrow and zero status outputs.
module subtractor_32
  import sub32_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] out
`ifdef SUBTRACT_32_FLAGS_EN
  ,
  output logic              overflow,
  output logic              borrow,
  output logic              zero
`endif
);

  logic [DATA_W-1:0]     b_inv;
  logic [DATA_W-1:0]     sum;
  logic [NUM_BLOCKS-1:0] blk_g;
  logic [NUM_BLOCKS-1:0] blk_p;
  logic [NUM_BLOCKS:0]   carry;

  assign b_inv = ~B;

  for (genvar k = 0; k < NUM_BLOCKS; k++) begin : g_blk
    cla_8 u_cla (
      .a   (A[k*CLA_BLOCK_W +: CLA_BLOCK_W]),
      .b   (b_inv[k*CLA_BLOCK_W +: CLA_BLOCK_W]),
      .cin (carry[k]),
      .sum (sum[k*CLA_BLOCK_W +: CLA_BLOCK_W]),
      .G   (blk_g[k]),
      .P   (blk_p[k])
    );
  end

  // Second-level lookahead: c0 = 1 (two's-complement +1), then c8, c16, c24, c32.
  always_comb begin
    carry = '0;
    for (int unsigned k = 0; k <= NUM_BLOCKS; k++) begin
      carry[k] = lookahead_carry(CLA_BLOCK_W'(blk_g), CLA_BLOCK_W'(blk_p), 1'b1, k);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out <= RESET_VALUE;
    end else begin
      out <= sum;
    end
  end

`ifdef SUBTRACT_32_FLAGS_EN
  logic overflow_c;
  logic borrow_c;
  logic zero_c;

  assign overflow_c = (A[DATA_W-1] ^ B[DATA_W-1]) & (sum[DATA_W-1] ^ A[DATA_W-1]);
  assign borrow_c   = ~carry[NUM_BLOCKS];
  assign zero_c     = (sum == '0);

  // Flags are captured on the same edge as out so they always describe the same operands.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
      borrow   <= 1'b0;
      zero     <= 1'b0;
    end else begin
      overflow <= overflow_c;
      borrow   <= borrow_c;
      zero     <= zero_c;
    end
  end
`else
  logic unused_c32;
  assign unused_c32 = carry[NUM_BLOCKS];
`endif

endmodule

// File: tb/tb_subtractor_32.sv
// Self-checking bench for subtractor_32: directed corner cases plus randomized operands and resets.
module tb_subtractor_32;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] out;
`ifdef SUBTRACT_32_FLAGS_EN
  logic        overflow;
  logic        borrow;
  logic        zero;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  subtractor_32 dut (
    .clock    (clock),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .out      (out)
`ifdef SUBTRACT_32_FLAGS_EN
    ,
    .overflow (overflow),
    .borrow   (borrow),
    .zero     (zero)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one operand pair, clock it, then compare against the arithmetic reference.
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic rst, input string tag);
    logic [31:0] e_out;
    logic        e_ovf;
    logic        e_brw;
    logic        e_zero;
    longint      diff;
    A     = a;
    B     = b;
    reset = rst;
    @(posedge clock);
    #1;
    if (rst) begin
      e_out  = 32'h0;
      e_ovf  = 1'b0;
      e_brw  = 1'b0;
      e_zero = 1'b0;
    end else begin
      e_out  = a - b;
      diff   = longint'($signed(a)) - longint'($signed(b));
      e_ovf  = (diff > 64'sd2147483647) || (diff < -64'sd2147483648);
      e_brw  = (a < b);
      e_zero = (a == b);
    end
    check({tag, " out"}, out, e_out);
`ifdef SUBTRACT_32_FLAGS_EN
    check({tag, " overflow"}, 32'(overflow), 32'(e_ovf));
    check({tag, " borrow"},   32'(borrow),   32'(e_brw));
    check({tag, " zero"},     32'(zero),     32'(e_zero));
`endif
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [6];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'h7FFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'hFFFF_FFFF;
    corners[5] = 32'h00FF_FF00;
    if ($urandom_range(3) == 0) return corners[$urandom_range(5)];
    return $urandom;
  endfunction

  initial begin
    apply(32'h1234_5678, 32'h0000_0001, 1'b1, "reset0");
    apply(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "reset1");

    for (int i = 0; i < 10; i++) begin
      apply(32'(i), 32'h0, 1'b0, $sformatf("count%0d", i));
    end

    apply(32'd5,          32'd7,          1'b0, "5_minus_7");
    apply(32'h8000_0000,  32'h0000_0001,  1'b0, "min_minus_1");
    apply(32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, "max_minus_neg1");
    apply(32'hDEAD_BEEF,  32'hDEAD_BEEF,  1'b0, "equal");
    apply(32'h0000_0000,  32'h0000_0001,  1'b0, "wrap");
    apply(32'h0000_0100,  32'h0000_0001,  1'b0, "carry_chain");

    // Reset for a single edge in the middle of a nonzero stream.
    apply(32'd100, 32'd1, 1'b0, "stream0");
    apply(32'd200, 32'd2, 1'b1, "stream_rst");
    apply(32'd300, 32'd3, 1'b0, "stream1");
    apply(32'd400, 32'd4, 1'b0, "stream2");

    for (int i = 0; i < 400; i++) begin
      apply(pick_operand(), pick_operand(), ($urandom_range(19) == 0), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
